rca_load_writeback_ctrl: RTL and testbench

RCA_LOAD_WRITEBACK_CTRL -- requirements
Module: rca_load_writeback_ctrl

---
 rtl/rca_config.sv | 14 +
 rtl/rca_load_writeback_ctrl_if.sv | 57 +++++
 rtl/rca_load_writeback_ctrl_fifo.sv | 68 ++++++
 rtl/rca_load_writeback_ctrl.sv | 114 +++++++++++
 tb/tb_rca_load_writeback_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rca_config.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rca_config : shared grid geometry, data width and row-index type      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rca_config;
  localparam int XLEN          = 32;
  localparam int GRID_NUM_ROWS = 6;
  localparam int MAX_IDS       = 8;
  localparam int ROW_W         = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;

  typedef logic [ROW_W-1:0] row_idx_t;
endpackage
`default_nettype wire

// File: rtl/rca_load_writeback_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rca_load_writeback_ctrl_if / fifo_interface : controller bus and the  |
// | queue handshake used by taiga_fifo.  Rev 1.0                          |
// +----------------------------------------------------------------------+
interface rca_load_writeback_ctrl_if
  import rca_config::XLEN;
#(
  parameter int GRID_NUM_ROWS = rca_config::GRID_NUM_ROWS,
  parameter int DEPTH         = rca_config::MAX_IDS
);
  localparam int ROW_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     flush;
  logic                     issue_valid;
  logic [ROW_W-1:0]         issue_row;
  logic                     issue_ready;
  logic                     load_complete;
  logic [XLEN-1:0]          load_data;
  logic [GRID_NUM_ROWS-1:0] row_ready;
  logic [GRID_NUM_ROWS-1:0] wb_valid;
  logic [XLEN-1:0]          wb_data;
  logic [CNT_W-1:0]         outstanding;
  logic                     idle;
  logic                     overflow_err;

  modport master (
    output flush, issue_valid, issue_row, load_complete, load_data, row_ready,
    input  issue_ready, wb_valid, wb_data, outstanding, idle, overflow_err
  );

  modport slave (
    input  flush, issue_valid, issue_row, load_complete, load_data, row_ready,
    output issue_ready, wb_valid, wb_data, outstanding, idle, overflow_err
  );
endinterface

interface fifo_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic [CNT_W-1:0]      count;

  modport enqueue   (output push, data_in, input full, count);
  modport dequeue   (output pop, input valid, data_out, count);
  modport structure (input push, pop, data_in, output data_out, valid, full, count);
endinterface
`default_nettype wire

// File: rtl/rca_load_writeback_ctrl_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | taiga_fifo : circular queue; caller guarantees no push-when-full      |
// | without a pop and no pop-when-empty.  Rev 1.0                         |
// +----------------------------------------------------------------------+
module taiga_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  fifo_interface.structure fifo
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo.push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (fifo.pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({fifo.push, fifo.pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (fifo.push && !clr) mem_q[wr_ptr_q] <= fifo.data_in;
  end

  assign fifo.data_out = mem_q[rd_ptr_q];
  assign fifo.valid    = (count_q != '0);
  assign fifo.full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo.count    = count_q;
endmodule
`default_nettype wire

// File: rtl/rca_load_writeback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rca_load_writeback_ctrl : pairs in-order load data with destination   |
// | grid rows and writes each result back once the row is ready. Rev 1.0  |
// +----------------------------------------------------------------------+
module rca_load_writeback_ctrl
  import rca_config::XLEN;
#(
  parameter int GRID_NUM_ROWS = rca_config::GRID_NUM_ROWS,
  parameter int DEPTH         = rca_config::MAX_IDS
) (
  input  logic clk,
  input  logic rst,
  rca_load_writeback_ctrl_if.slave bus
);
  localparam int ROW_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WAIT_ROW  = 2'd2
  } state_t;

  fifo_interface #(.DATA_WIDTH(ROW_W), .FIFO_DEPTH(DEPTH)) dest_fifo ();
  fifo_interface #(.DATA_WIDTH(XLEN),  .FIFO_DEPTH(DEPTH)) data_fifo ();

  taiga_fifo #(.DATA_WIDTH(ROW_W), .FIFO_DEPTH(DEPTH)) u_dest_fifo (
    .clk(clk), .rst(rst), .clr(bus.flush), .fifo(dest_fifo)
  );
  taiga_fifo #(.DATA_WIDTH(XLEN), .FIFO_DEPTH(DEPTH)) u_data_fifo (
    .clk(clk), .rst(rst), .clr(bus.flush), .fifo(data_fifo)
  );

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         outstanding_q, outstanding_d;
  logic [CNT_W-1:0]         data_cnt_d;
  logic [GRID_NUM_ROWS-1:0] wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]          wb_data_q, wb_data_d;
  logic                     overflow_q, overflow_d;

  logic [ROW_W-1:0] dest_head;
  logic             row_ok, match, issue_acc, data_push, err;

  assign dest_head = dest_fifo.data_out;
  assign row_ok    = (32'(bus.issue_row) < GRID_NUM_ROWS);
  assign match     = !bus.flush && dest_fifo.valid && data_fifo.valid && bus.row_ready[dest_head];
  // A full queue still takes a push in the cycle its head is popped.
  assign issue_acc = !bus.flush && bus.issue_valid && row_ok && (!dest_fifo.full || match);
  assign data_push = !bus.flush && bus.load_complete && (!data_fifo.full || match);
  // Data with no waiting destination means more returns than issues.
  assign err = !bus.flush &&
               ((bus.issue_valid && (!row_ok || (dest_fifo.full && !match))) ||
                (bus.load_complete && ((data_fifo.count >= dest_fifo.count) ||
                                       (data_fifo.full && !match))));

  assign dest_fifo.push    = issue_acc;
  assign dest_fifo.data_in = bus.issue_row;
  assign dest_fifo.pop     = match;
  assign data_fifo.push    = data_push;
  assign data_fifo.data_in = bus.load_data;
  assign data_fifo.pop     = match;

  always_comb begin
    outstanding_d = outstanding_q;
    data_cnt_d    = data_fifo.count;
    wb_valid_d    = '0;
    wb_data_d     = wb_data_q;
    overflow_d    = overflow_q | err;
    state_d       = IDLE;
    if (bus.flush) begin
      outstanding_d = '0;
      data_cnt_d    = '0;
    end else begin
      case ({issue_acc, match})
        2'b10: if (outstanding_q != CNT_W'(DEPTH)) outstanding_d = outstanding_q + 1'b1;
        2'b01: if (outstanding_q != '0)            outstanding_d = outstanding_q - 1'b1;
        default: outstanding_d = outstanding_q;
      endcase
      data_cnt_d = data_fifo.count + CNT_W'(data_push) - CNT_W'(match);
      if (match) begin
        wb_valid_d = GRID_NUM_ROWS'(1) << dest_head;
        wb_data_d  = data_fifo.data_out;
      end
    end
    if (outstanding_d == '0)   state_d = IDLE;
    else if (data_cnt_d == '0) state_d = WAIT_DATA;
    else                       state_d = WAIT_ROW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      wb_valid_q    <= '0;
      wb_data_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.issue_ready  = !dest_fifo.full;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.outstanding  = outstanding_q;
  assign bus.idle         = (outstanding_q == '0) && !data_fifo.valid;
  assign bus.overflow_err = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_rca_load_writeback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rca_load_writeback_ctrl : directed steps with a writeback          |
// | scoreboard.  Rev 1.0                                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rca_load_writeback_ctrl;
  import rca_config::XLEN;
  localparam int ROWS  = rca_config::GRID_NUM_ROWS;
  localparam int DEPTH = rca_config::MAX_IDS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef struct {
    logic [ROWS-1:0] strobe;
    logic [XLEN-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  rca_load_writeback_ctrl_if bus ();
  rca_load_writeback_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  int   rowq[$];
  int   total  = 0;
  int   bad    = 0;
  int   wb_cnt = 0;
  int   snap;

  function automatic logic [ROWS-1:0] oh(input int r);
    logic [ROWS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; any writeback strobe is matched against the scoreboard head.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (bus.wb_valid != '0) begin
      wb_cnt++;
      if (sb.size() == 0) chk("wb_unexpected", 64'(bus.wb_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("wb_valid", 64'(bus.wb_valid), 64'(e.strobe));
        chk("wb_data",  64'(bus.wb_data),  64'(e.data));
      end
    end
  endtask

  task automatic issue(input int r);
    bus.issue_valid = 1'b1;
    bus.issue_row   = ROW_W'(r);
    if (r < ROWS) rowq.push_back(r);
    cycle();
    bus.issue_valid = 1'b0;
  endtask

  task automatic complete(input logic [XLEN-1:0] d, input bit has_dest);
    exp_t e;
    if (has_dest) begin
      e.strobe = oh(rowq.pop_front());
      e.data   = d;
      sb.push_back(e);
    end
    bus.load_complete = 1'b1;
    bus.load_data     = d;
    cycle();
    bus.load_complete = 1'b0;
  endtask

  task automatic model_clear();
    rowq.delete();
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    bus.flush         = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.issue_row     = '0;
    bus.load_complete = 1'b0;
    bus.load_data     = '0;
    bus.row_ready     = '1;
    rst               = 1'b1;
    repeat (2) cycle();
    chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
    chk("rst_idle",        64'(bus.idle), 64'd1);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_wb_valid",    64'(bus.wb_valid), 64'd0);
    chk("rst_wb_data",     64'(bus.wb_data), 64'd0);
    chk("rst_overflow",    64'(bus.overflow_err), 64'd0);
    rst = 1'b0;
    cycle();

    // In-order writeback on consecutive cycles.
    issue(2);
    issue(0);
    chk("t1_outstanding2", 64'(bus.outstanding), 64'd2);
    snap = wb_cnt;
    complete(32'hAAAA, 1'b1);
    chk("t1_no_wb_yet", 64'(wb_cnt - snap), 64'd0);
    complete(32'hBBBB, 1'b1);
    chk("t1_first_wb", 64'(wb_cnt - snap), 64'd1);
    cycle();
    chk("t1_second_wb", 64'(wb_cnt - snap), 64'd2);
    chk("t1_outstanding0", 64'(bus.outstanding), 64'd0);
    chk("t1_idle", 64'(bus.idle), 64'd1);

    // Head blocked by a row that is not ready.
    bus.row_ready[1] = 1'b0;
    issue(1);
    snap = wb_cnt;
    complete(32'h1234, 1'b1);
    chk("t2_state_wait_row", 64'(dut.state_q), 64'd2);
    repeat (5) cycle();
    chk("t2_blocked", 64'(wb_cnt - snap), 64'd0);
    chk("t2_idle_low", 64'(bus.idle), 64'd0);
    bus.row_ready[1] = 1'b1;
    cycle();
    chk("t2_released", 64'(wb_cnt - snap), 64'd1);
    chk("t2_outstanding0", 64'(bus.outstanding), 64'd0);

    // Full destination queue, then push and pop in the same cycle.
    bus.row_ready = '0;
    for (int i = 0; i < DEPTH; i++) issue(i % ROWS);
    chk("t3_issue_ready", 64'(bus.issue_ready), 64'd0);
    chk("t3_outstanding_full", 64'(bus.outstanding), 64'(DEPTH));
    complete(32'h5000, 1'b1);
    bus.row_ready = '1;
    snap = wb_cnt;
    issue(3);
    chk("t3_match_wb", 64'(wb_cnt - snap), 64'd1);
    chk("t3_outstanding_stays", 64'(bus.outstanding), 64'(DEPTH));
    chk("t3_no_overflow", 64'(bus.overflow_err), 64'd0);
    for (int i = 1; i <= DEPTH; i++) complete(XLEN'(32'h5000 + i), 1'b1);
    repeat (2) cycle();
    chk("t3_drained", 64'(sb.size()), 64'd0);
    chk("t3_outstanding0", 64'(bus.outstanding), 64'd0);
    chk("t3_idle", 64'(bus.idle), 64'd1);

    // Orphan data and an out-of-range row both raise the sticky error.
    complete(32'hDEAD, 1'b0);
    chk("t4_orphan_overflow", 64'(bus.overflow_err), 64'd1);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    repeat (2) cycle();
    chk("t4_sticky", 64'(bus.overflow_err), 64'd1);
    chk("t4_flush_idle", 64'(bus.idle), 64'd1);
    do_reset();
    chk("t4_reset_clears", 64'(bus.overflow_err), 64'd0);
    issue(ROWS);
    chk("t4_bad_row_overflow", 64'(bus.overflow_err), 64'd1);
    chk("t4_bad_row_not_pushed", 64'(bus.outstanding), 64'd0);

    // Flush together with a completion discards everything.
    bus.row_ready = '0;
    issue(0);
    issue(1);
    issue(2);
    complete(32'h1, 1'b1);
    chk("t5_outstanding3", 64'(bus.outstanding), 64'd3);
    model_clear();
    snap = wb_cnt;
    bus.flush         = 1'b1;
    bus.load_complete = 1'b1;
    bus.load_data     = 32'h2;
    cycle();
    bus.flush         = 1'b0;
    bus.load_complete = 1'b0;
    chk("t5_outstanding0", 64'(bus.outstanding), 64'd0);
    chk("t5_idle", 64'(bus.idle), 64'd1);
    chk("t5_state_idle", 64'(dut.state_q), 64'd0);
    bus.row_ready = '1;
    repeat (4) cycle();
    chk("t5_no_wb", 64'(wb_cnt - snap), 64'd0);

    // Asynchronous reset between edges with loads pending.
    bus.row_ready = '0;
    issue(4);
    issue(5);
    complete(32'h77, 1'b1);
    chk("t6_pending", 64'(bus.outstanding), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_outstanding", 64'(bus.outstanding), 64'd0);
    chk("t6_async_idle", 64'(bus.idle), 64'd1);
    chk("t6_async_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("t6_async_overflow", 64'(bus.overflow_err), 64'd0);
    chk("t6_async_issue_ready", 64'(bus.issue_ready), 64'd1);
    model_clear();
    snap = wb_cnt;
    bus.row_ready = '1;
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    chk("t6_no_wb_after_rst", 64'(wb_cnt - snap), 64'd0);
    issue(3);
    complete(32'h99, 1'b1);
    cycle();
    chk("t6_wb_after_release", 64'(wb_cnt - snap), 64'd1);
    chk("t6_outstanding0", 64'(bus.outstanding), 64'd0);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
